// File: rtl/bp_hb_payload_tracker_pkg.sv
// Shared types and defaults for the BP-to-HammerBlade payload tracker.
package bp_hb_payload_tracker_pkg;

    typedef enum logic [0:0] {
        e_bp_unicore_hammerblade_cfg = 1'b0
    } bp_params_e;

    localparam int unsigned bp_hb_tracker_els_lp       = 32'd8;
    localparam int unsigned bp_hb_tracker_tag_width_lp = $clog2(bp_hb_tracker_els_lp);

    typedef logic [bp_hb_tracker_tag_width_lp-1:0] bp_hb_tracker_tag_t;

    function automatic int unsigned mem_noc_did_width(input bp_params_e cfg);
        case (cfg)
            e_bp_unicore_hammerblade_cfg: return 32'd19;
            default:                      return 32'd19;
        endcase
    endfunction

endpackage

// File: rtl/bp_hb_payload_tracker_age.sv
// Per-entry age counters with a sticky lowest-index timeout capture.
module bp_hb_payload_tracker_age
    import bp_hb_payload_tracker_pkg::*;
#(
    parameter int els_p        = 8,
    parameter int timeout_p    = 1024,
    localparam int tag_width_lp = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [els_p-1:0]        busy_i,
    input  logic [els_p-1:0]        clr_i,
    output logic                    timeout_o,
    output logic [tag_width_lp-1:0] timeout_tag_o
);

    localparam int age_width_lp = $clog2(timeout_p + 1);
    localparam logic [age_width_lp-1:0] age_max_lp = age_width_lp'(timeout_p);

    logic [age_width_lp-1:0] age_r [els_p];
    logic                    hit_found_s;
    logic [tag_width_lp-1:0] hit_tag_s;
    logic                    timeout_r;
    logic [tag_width_lp-1:0] timeout_tag_r;

    // Age counters: cleared on allocation, count while busy, saturate at the limit
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < els_p; i++) begin
            if (reset_i || clr_i[i]) begin
                age_r[i] <= '0;
            end else if (busy_i[i] && (age_r[i] != age_max_lp)) begin
                age_r[i] <= age_r[i] + age_width_lp'(1);
            end else begin
                age_r[i] <= age_r[i];
            end
        end
    end

    // Lowest-index busy entry that has reached the limit
    always_comb begin
        hit_found_s = 1'b0;
        hit_tag_s   = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (busy_i[i] && (age_r[i] == age_max_lp)) begin
                hit_found_s = 1'b1;
                hit_tag_s   = tag_width_lp'(i);
            end else begin
                hit_found_s = hit_found_s;
            end
        end
    end

    // Sticky capture of the first timeout
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timeout_r     <= 1'b0;
            timeout_tag_r <= '0;
        end else if (!timeout_r && hit_found_s) begin
            timeout_r     <= 1'b1;
            timeout_tag_r <= hit_tag_s;
        end else begin
            timeout_r     <= timeout_r;
            timeout_tag_r <= timeout_tag_r;
        end
    end

    assign timeout_o     = timeout_r;
    assign timeout_tag_o = timeout_tag_r;

endmodule

// File: rtl/bp_hb_payload_tracker.sv
// Outstanding-request tag/payload tracker; the optional watchdog is enabled
// by defining BP_HB_TRACKER_TIMEOUT_EN.
module bp_hb_payload_tracker
    import bp_hb_payload_tracker_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_unicore_hammerblade_cfg,
    parameter int els_p               = bp_hb_tracker_els_lp,
    parameter int payload_width_p     = mem_noc_did_width(bp_params_p),
    parameter int timeout_p           = 1024,
    localparam int tag_width_lp       = $clog2(els_p),
    localparam int count_width_lp     = $clog2(els_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       alloc_v_i,
    input  logic [payload_width_p-1:0] alloc_payload_i,
    output logic                       alloc_ready_and_o,
    output logic [tag_width_lp-1:0]    alloc_tag_o,
    input  logic                       ret_v_i,
    input  logic [tag_width_lp-1:0]    ret_tag_i,
    output logic                       ret_ready_and_o,
    output logic [payload_width_p-1:0] ret_payload_o,
    output logic [count_width_lp-1:0]  count_o,
    output logic                       empty_o,
    output logic                       err_o,
    output logic                       timeout_o,
    output logic [tag_width_lp-1:0]    timeout_tag_o
);

    localparam logic [count_width_lp-1:0] full_lp = count_width_lp'(els_p);
    localparam logic [els_p-1:0]          one_lp  = {{(els_p-1){1'b0}}, 1'b1};

    logic [els_p-1:0]           busy_r;
    logic [payload_width_p-1:0] payload_r [els_p];
    logic [count_width_lp-1:0]  count_r;
    logic                       err_r;

    logic                    free_found_s;
    logic [tag_width_lp-1:0] free_tag_s;
    logic                    alloc_fire_s;
    logic                    ret_hit_s;
    logic                    ret_miss_s;
    logic [els_p-1:0]        alloc_onehot_s;
    logic [els_p-1:0]        ret_onehot_s;

    // Priority encoder over the pre-edge busy vector: lowest free index wins
    always_comb begin
        free_found_s = 1'b0;
        free_tag_s   = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (!busy_r[i]) begin
                free_found_s = 1'b1;
                free_tag_s   = tag_width_lp'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    assign alloc_fire_s   = alloc_v_i & free_found_s;
    assign ret_hit_s      = ret_v_i & busy_r[ret_tag_i];
    assign ret_miss_s     = ret_v_i & ~busy_r[ret_tag_i];
    assign alloc_onehot_s = alloc_fire_s ? (one_lp << free_tag_s) : '0;
    assign ret_onehot_s   = ret_hit_s ? (one_lp << ret_tag_i) : '0;

    // Busy vector, occupancy counter and sticky error flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_r  <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            busy_r <= (busy_r | alloc_onehot_s) & ~ret_onehot_s;
            case ({alloc_fire_s, ret_hit_s})
                2'b10:   count_r <= (count_r == full_lp) ? count_r : count_r + count_width_lp'(1);
                2'b01:   count_r <= (count_r == '0) ? count_r : count_r - count_width_lp'(1);
                default: count_r <= count_r;
            endcase
            err_r <= err_r | ret_miss_s;
        end
    end

    // Payload storage is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (alloc_fire_s) begin
            payload_r[free_tag_s] <= alloc_payload_i;
        end else begin
            payload_r[free_tag_s] <= payload_r[free_tag_s];
        end
    end

    assign alloc_ready_and_o = free_found_s;
    assign alloc_tag_o       = free_tag_s;
    assign ret_ready_and_o   = 1'b1;
    assign ret_payload_o     = payload_r[ret_tag_i];
    assign count_o           = count_r;
    assign empty_o           = (count_r == '0);
    assign err_o             = err_r;

`ifdef BP_HB_TRACKER_TIMEOUT_EN
    bp_hb_payload_tracker_age #(
        .els_p     (els_p),
        .timeout_p (timeout_p)
    ) age (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .busy_i        (busy_r),
        .clr_i         (alloc_onehot_s),
        .timeout_o     (timeout_o),
        .timeout_tag_o (timeout_tag_o)
    );
`else
    assign timeout_o     = 1'b0;
    assign timeout_tag_o = '0;
`endif

endmodule

// File: tb/tb_bp_hb_payload_tracker.sv
// Scoreboard bench: stimulus queues expected tags/payloads, a negedge monitor checks them.
module tb_bp_hb_payload_tracker;

    localparam int ELS = 8;
    localparam int PW  = 19;
    localparam int TW  = 3;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          alloc_v_i;
    logic [PW-1:0] alloc_payload_i;
    logic          alloc_ready_and_o;
    logic [TW-1:0] alloc_tag_o;
    logic          ret_v_i;
    logic [TW-1:0] ret_tag_i;
    logic          ret_ready_and_o;
    logic [PW-1:0] ret_payload_o;
    logic [CW-1:0] count_o;
    logic          empty_o;
    logic          err_o;
    logic          timeout_o;
    logic [TW-1:0] timeout_tag_o;

    bp_hb_payload_tracker #(
        .els_p           (ELS),
        .payload_width_p (PW),
        .timeout_p       (16)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .alloc_v_i         (alloc_v_i),
        .alloc_payload_i   (alloc_payload_i),
        .alloc_ready_and_o (alloc_ready_and_o),
        .alloc_tag_o       (alloc_tag_o),
        .ret_v_i           (ret_v_i),
        .ret_tag_i         (ret_tag_i),
        .ret_ready_and_o   (ret_ready_and_o),
        .ret_payload_o     (ret_payload_o),
        .count_o           (count_o),
        .empty_o           (empty_o),
        .err_o             (err_o),
        .timeout_o         (timeout_o),
        .timeout_tag_o     (timeout_tag_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          chk;
        logic [PW-1:0] pay;
    } ret_exp_t;

    logic [TW-1:0] alloc_q [$];
    ret_exp_t      ret_q [$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [PW-1:0] ap, input logic rv, input logic [TW-1:0] rt);
        @(posedge clk);
        #1;
        alloc_v_i       = av;
        alloc_payload_i = ap;
        ret_v_i         = rv;
        ret_tag_i       = rt;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic alloc(input logic [PW-1:0] pay, input logic [TW-1:0] exp_tag);
        drive(1'b1, pay, 1'b0, '0);
        alloc_q.push_back(exp_tag);
    endtask

    task automatic ret(input logic [TW-1:0] tag, input logic c, input logic [PW-1:0] exp_pay);
        drive(1'b0, '0, 1'b1, tag);
        ret_q.push_back({c, exp_pay});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        alloc_v_i = 1'b0;
        ret_v_i = 1'b0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    // Monitor: compare every granted tag and every returned payload against the queues
    always @(negedge clk) begin
        logic [TW-1:0] e_tag;
        ret_exp_t      e_ret;
        if (!reset_i) begin
            if (alloc_v_i && alloc_ready_and_o) begin
                if (alloc_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL alloc_grant: unexpected grant tag %0d, none required", alloc_tag_o);
                end else begin
                    e_tag = alloc_q.pop_front();
                    chk("alloc_tag", 32'(alloc_tag_o), 32'(e_tag));
                end
            end
            if (ret_v_i) begin
                if (ret_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ret_payload: unexpected return tag %0d", ret_tag_i);
                end else begin
                    e_ret = ret_q.pop_front();
                    if (e_ret.chk) chk("ret_payload", 32'(ret_payload_o), 32'(e_ret.pay));
                end
            end
        end
    end

    initial begin
        reset_i = 1'b1;
        alloc_v_i = 1'b0;
        alloc_payload_i = '0;
        ret_v_i = 1'b0;
        ret_tag_i = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_ready", 32'(alloc_ready_and_o), 32'd1);
        chk("rst_tag", 32'(alloc_tag_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_timeout_tag", 32'(timeout_tag_o), 32'd0);
        chk("ret_ready", 32'(ret_ready_and_o), 32'd1);

        // Fill all eight entries
        for (int i = 0; i < ELS; i++) alloc(PW'(i + 1), TW'(i));
        idle();
        chk("full_count", 32'(count_o), 32'd8);
        chk("full_ready", 32'(alloc_ready_and_o), 32'd0);
        chk("full_empty", 32'(empty_o), 32'd0);

        // Return tag 3 while full with alloc held; the slot becomes grantable next cycle
        drive(1'b1, 19'h00055, 1'b1, 3'd3);
        ret_q.push_back({1'b1, 19'h00004});
        alloc(19'h00033, 3'd3);
        chk("ready_after_ret", 32'(alloc_ready_and_o), 32'd1);
        chk("count_after_ret", 32'(count_o), 32'd7);
        idle();
        chk("refill_count", 32'(count_o), 32'd8);
        chk("refill_ready", 32'(alloc_ready_and_o), 32'd0);
        ret(3'd3, 1'b1, 19'h00033);
        idle();
        chk("count_7", 32'(count_o), 32'd7);

        // Leave tags 0 and 5 busy, then alloc and return tag 0 together
        do_reset();
        for (int i = 0; i < 6; i++) alloc(PW'(32'h100 + i), TW'(i));
        for (int i = 1; i < 5; i++) ret(TW'(i), 1'b1, PW'(32'h100 + i));
        idle();
        chk("two_busy_count", 32'(count_o), 32'd2);
        drive(1'b1, 19'h000A0, 1'b1, 3'd0);
        alloc_q.push_back(3'd1);
        ret_q.push_back({1'b1, 19'h00100});
        alloc(19'h000B0, 3'd0);
        chk("simul_count", 32'(count_o), 32'd2);
        idle();
        chk("three_busy_count", 32'(count_o), 32'd3);

        // Return to a free tag sets the sticky error only
        ret(3'd6, 1'b0, '0);
        idle();
        chk("err_set", 32'(err_o), 32'd1);
        chk("err_count", 32'(count_o), 32'd3);
        repeat (3) idle();
        chk("err_sticky", 32'(err_o), 32'd1);
        ret(3'd1, 1'b1, 19'h000A0);
        idle();
        chk("err_sticky2", 32'(err_o), 32'd1);
        chk("count_after_ret1", 32'(count_o), 32'd2);

        // Reset with four outstanding discards everything
        alloc(19'h000C0, 3'd1);
        alloc(19'h000C1, 3'd2);
        idle();
        chk("four_count", 32'(count_o), 32'd4);
        do_reset();
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_empty", 32'(empty_o), 32'd1);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        chk("mid_rst_tag", 32'(alloc_tag_o), 32'd0);
        ret(3'd0, 1'b0, '0);
        idle();
        chk("post_rst_err", 32'(err_o), 32'd1);
        chk("post_rst_count", 32'(count_o), 32'd0);

        // Watchdog
        do_reset();
        alloc(19'h00011, 3'd0);
        alloc(19'h00022, 3'd1);
        repeat (10) idle();
        chk("timeout_early", 32'(timeout_o), 32'd0);
`ifdef BP_HB_TRACKER_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (!timeout_o && n < 40) begin
                idle();
                n++;
            end
            chk("timeout_set", 32'(timeout_o), 32'd1);
            chk("timeout_tag", 32'(timeout_tag_o), 32'd0);
        end
`else
        repeat (20) idle();
        chk("timeout_off", 32'(timeout_o), 32'd0);
        chk("timeout_tag_off", 32'(timeout_tag_o), 32'd0);
`endif

        idle();
        chk("alloc_q_drained", 32'(alloc_q.size()), 32'd0);
        chk("ret_q_drained", 32'(ret_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
